// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit and its decoder.
// Holds the FSM states, instruction classes, control-field codes and opcode constants.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CL_OP,
        CL_OPIMM,
        CL_LUI,
        CL_AUIPC,
        CL_JAL,
        CL_JALR,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH
    } inst_class_t;

    localparam logic [2:0] IMM_R = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    localparam logic [3:0] ALU_DF    = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_SLL   = 4'd3;
    localparam logic [3:0] ALU_SLT   = 4'd4;
    localparam logic [3:0] ALU_SLTU  = 4'd5;
    localparam logic [3:0] ALU_XOR   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_OR    = 4'd9;
    localparam logic [3:0] ALU_AND   = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] CAUSE_NONE      = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL   = 2'd1;
    localparam logic [1:0] CAUSE_FETCH_TO  = 2'd2;
    localparam logic [1:0] CAUSE_MEM_TO    = 2'd3;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU op for the funct3 field of OP/OP-IMM with the base funct7.
    function automatic logic [3:0] alu_of_funct3(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder: instruction register to class, datapath controls and
// an illegal flag for any opcode/funct3/funct7 combination outside the base integer set.
module rv32i_decoder
    import multicycle_control_pkg::*;
(
    input  logic [31:0]  i_ir,
    output inst_class_t  o_class,
    output logic [2:0]   o_imm_sel,
    output logic [3:0]   o_alu_sel,
    output logic [1:0]   o_wb_sel,
    output logic         o_asel,
    output logic         o_bsel,
    output logic         o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused_fields;

    assign w_opcode        = i_ir[6:0];
    assign w_funct3        = i_ir[14:12];
    assign w_funct7        = i_ir[31:25];
    assign w_unused_fields = ^{i_ir[24:15], i_ir[11:7]};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        o_class   = CL_OP;
        o_imm_sel = IMM_R;
        o_alu_sel = ALU_DF;
        o_wb_sel  = WB_MEM;
        o_asel    = 1'b0;
        o_bsel    = 1'b0;
        o_illegal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                o_class  = CL_OP;
                o_wb_sel = WB_ALU;
                if (w_funct7 == F7_BASE) begin
                    o_alu_sel = alu_of_funct3(w_funct3);
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
                    o_alu_sel = ALU_SUB;
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
                    o_alu_sel = ALU_SRA;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                o_class   = CL_OPIMM;
                o_imm_sel = IMM_I;
                o_bsel    = 1'b1;
                o_wb_sel  = WB_ALU;
                o_alu_sel = alu_of_funct3(w_funct3);
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (w_funct3 == 3'b001 && w_funct7 != F7_BASE) begin
                    o_illegal = 1'b1;
                end else if (w_funct3 == 3'b101) begin
                    if (w_funct7 == F7_ALT) begin
                        o_alu_sel = ALU_SRA;
                    end else if (w_funct7 != F7_BASE) begin
                        o_illegal = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                o_class   = CL_LUI;
                o_imm_sel = IMM_U;
                o_bsel    = 1'b1;
                o_alu_sel = ALU_PASSB;
                o_wb_sel  = WB_ALU;
            end
            OPC_AUIPC: begin
                o_class   = CL_AUIPC;
                o_imm_sel = IMM_U;
                o_asel    = 1'b1;
                o_bsel    = 1'b1;
                o_alu_sel = ALU_ADD;
                o_wb_sel  = WB_ALU;
            end
            OPC_JAL: begin
                o_class   = CL_JAL;
                o_imm_sel = IMM_J;
                o_asel    = 1'b1;
                o_bsel    = 1'b1;
                o_alu_sel = ALU_ADD;
                o_wb_sel  = WB_PC4;
            end
            OPC_JALR: begin
                o_class   = CL_JALR;
                o_imm_sel = IMM_I;
                o_bsel    = 1'b1;
                o_alu_sel = ALU_ADD;
                o_wb_sel  = WB_PC4;
                o_illegal = (w_funct3 != 3'b000);
            end
            OPC_LOAD: begin
                o_class   = CL_LOAD;
                o_imm_sel = IMM_I;
                o_bsel    = 1'b1;
                o_alu_sel = ALU_ADD;
                o_wb_sel  = WB_MEM;
                o_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
            end
            OPC_STORE: begin
                o_class   = CL_STORE;
                o_imm_sel = IMM_S;
                o_bsel    = 1'b1;
                o_alu_sel = ALU_ADD;
                o_illegal = (w_funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                o_class   = CL_BRANCH;
                o_imm_sel = IMM_B;
                o_asel    = 1'b1;
                o_bsel    = 1'b1;
                o_alu_sel = ALU_ADD;
                o_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky TRAP, memory wait
// timeout and a retired-instruction counter. All outputs are forced low while rst is high.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32,
    parameter int ALU_W       = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_inst,
    input  logic              i_mem_ready,
    input  logic              i_BrEq,
    input  logic              i_BrLt,
    output logic              o_mem_req,
    output logic              o_MemRW,
    output logic              o_PCSel,
    output logic              o_PCWEn,
    output logic              o_IRWEn,
    output logic [2:0]        o_immSel,
    output logic              o_RegWEn,
    output logic              o_BrUn,
    output logic              o_Asel,
    output logic              o_Bsel,
    output logic [ALU_W-1:0]  o_ALUSel,
    output logic [1:0]        o_WBSel,
    output logic [CNT_W-1:0]  o_instret,
    output logic              o_trap,
    output logic [1:0]        o_cause
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_ir;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_instret;
    logic [1:0]        r_cause;
    logic [1:0]        w_next_cause;
    logic              w_retire;
    logic              w_wait_expired;
    logic              w_branch_taken;

    inst_class_t       w_class;
    logic [2:0]        w_imm_sel;
    logic [3:0]        w_alu_sel;
    logic [1:0]        w_wb_sel;
    logic              w_asel;
    logic              w_bsel;
    logic              w_illegal;

    rv32i_decoder u_decoder (
        .i_ir      (r_ir),
        .o_class   (w_class),
        .o_imm_sel (w_imm_sel),
        .o_alu_sel (w_alu_sel),
        .o_wb_sel  (w_wb_sel),
        .o_asel    (w_asel),
        .o_bsel    (w_bsel),
        .o_illegal (w_illegal)
    );

    assign w_wait_expired = (r_wait == WAIT_W'(MEM_TIMEOUT - 1)) && !i_mem_ready;
    assign w_branch_taken = (r_ir[14] ? i_BrLt : i_BrEq) ^ r_ir[12];

    always_comb begin
        w_next       = r_state;
        w_next_cause = r_cause;
        w_retire     = 1'b0;
        o_mem_req    = 1'b0;
        o_MemRW      = 1'b0;
        o_PCSel      = 1'b0;
        o_PCWEn      = 1'b0;
        o_IRWEn      = 1'b0;
        o_immSel     = IMM_R;
        o_RegWEn     = 1'b0;
        o_BrUn       = 1'b0;
        o_Asel       = 1'b0;
        o_Bsel       = 1'b0;
        o_ALUSel     = '0;
        o_WBSel      = WB_MEM;
        o_instret    = '0;
        o_trap       = 1'b0;
        o_cause      = CAUSE_NONE;
        if (!rst) begin
            o_instret = r_instret;
            o_cause   = r_cause;
            if (r_state inside {ST_EXEC, ST_MEM, ST_WB}) begin
                o_immSel = w_imm_sel;
                o_ALUSel = ALU_W'(w_alu_sel);
                o_WBSel  = w_wb_sel;
                o_Asel   = w_asel;
                o_Bsel   = w_bsel;
            end
            case (r_state)
                ST_FETCH: begin
                    o_mem_req = 1'b1;
                    if (i_mem_ready) begin
                        o_IRWEn = 1'b1;
                        w_next  = ST_DECODE;
                    end else if (w_wait_expired) begin
                        w_next       = ST_TRAP;
                        w_next_cause = CAUSE_FETCH_TO;
                    end
                end
                ST_DECODE: begin
                    if (w_illegal) begin
                        w_next       = ST_TRAP;
                        w_next_cause = CAUSE_ILLEGAL;
                    end else begin
                        w_next = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_class == CL_BRANCH) begin
                        o_BrUn   = r_ir[13];
                        o_PCSel  = w_branch_taken;
                        o_PCWEn  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end else if (w_class == CL_LOAD || w_class == CL_STORE) begin
                        w_next = ST_MEM;
                    end else begin
                        w_next = ST_WB;
                    end
                end
                ST_MEM: begin
                    o_mem_req = 1'b1;
                    o_MemRW   = (w_class == CL_STORE);
                    if (i_mem_ready) begin
                        if (w_class == CL_STORE) begin
                            o_PCWEn  = 1'b1;
                            w_retire = 1'b1;
                            w_next   = ST_FETCH;
                        end else begin
                            w_next = ST_WB;
                        end
                    end else if (w_wait_expired) begin
                        w_next       = ST_TRAP;
                        w_next_cause = CAUSE_MEM_TO;
                    end
                end
                ST_WB: begin
                    o_RegWEn = 1'b1;
                    o_PCWEn  = 1'b1;
                    o_PCSel  = (w_class == CL_JAL) || (w_class == CL_JALR);
                    w_retire = 1'b1;
                    w_next   = ST_FETCH;
                end
                ST_TRAP: begin
                    o_trap = 1'b1;
                end
                default: begin
                    w_next = ST_FETCH;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_ir      <= '0;
            r_wait    <= '0;
            r_instret <= '0;
            r_cause   <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            r_cause <= w_next_cause;
            if (o_IRWEn) begin
                r_ir <= i_inst;
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            // Only consecutive unanswered requests within one state count toward the timeout.
            if (w_next != r_state || i_mem_ready || !o_mem_req) begin
                r_wait <= '0;
            end else begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: a per-instruction model expands each directed vector into the
// per-cycle outputs it must produce; one process drives the vectors and compares every cycle.
module tb_multicycle_control;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int ALU_W       = 4;
    localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       inst = '0;
    logic              mem_ready = 1'b0;
    logic              br_eq = 1'b0;
    logic              br_lt = 1'b0;
    logic              mem_req, mem_rw, pc_sel, pc_wen, ir_wen, reg_wen, br_un, a_sel, b_sel, trap;
    logic [2:0]        imm_sel;
    logic [ALU_W-1:0]  alu_sel;
    logic [1:0]        wb_sel, cause;
    logic [CNT_W-1:0]  instret;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W), .ALU_W(ALU_W)) dut (
        .clk(clk), .rst(rst), .i_inst(inst), .i_mem_ready(mem_ready),
        .i_BrEq(br_eq), .i_BrLt(br_lt),
        .o_mem_req(mem_req), .o_MemRW(mem_rw), .o_PCSel(pc_sel), .o_PCWEn(pc_wen),
        .o_IRWEn(ir_wen), .o_immSel(imm_sel), .o_RegWEn(reg_wen), .o_BrUn(br_un),
        .o_Asel(a_sel), .o_Bsel(b_sel), .o_ALUSel(alu_sel), .o_WBSel(wb_sel),
        .o_instret(instret), .o_trap(trap), .o_cause(cause)
    );

    typedef struct packed {
        logic             mem_req, memrw, pcsel, pcwen, irwen;
        logic [2:0]       imm;
        logic             regwen, brun, asel, bsel;
        logic [3:0]       alu;
        logic [1:0]       wb;
        logic [CNT_W-1:0] instret;
        logic             trap;
        logic [1:0]       cause;
    } obs_t;

    typedef struct {
        logic        rst;
        logic [31:0] inst;
        logic        ready, breq, brlt;
        obs_t        exp;
        string       tag;
    } step_t;

    typedef struct packed {
        logic [2:0] imm;
        logic [3:0] alu;
        logic [1:0] wb;
        logic       asel, bsel, legal, is_load, is_store, is_branch, is_jump;
    } spec_t;

    step_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    m_instret = 0;
    logic  m_trapped = 1'b0;
    logic [1:0] m_cause = 2'd0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Controls an instruction must present, by the mnemonic table of the ISA.
    function automatic spec_t spec_of(input logic [31:0] w);
        spec_t s;
        logic [3:0] by_f3 [8];
        logic [2:0] f3;
        logic [6:0] f7;
        by_f3 = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10};
        f3 = w[14:12];
        f7 = w[31:25];
        s = '0;
        case (w[6:0])
            7'h33: begin
                s.wb = 2'd1; s.alu = by_f3[f3];
                s.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                if (f7 == 7'h20) s.alu = (f3 == 3'd0) ? 4'd2 : 4'd8;
            end
            7'h13: begin
                s.imm = 3'd1; s.bsel = 1'b1; s.wb = 2'd1; s.alu = by_f3[f3]; s.legal = 1'b1;
                if (f3 == 3'd1) s.legal = (f7 == 7'h00);
                if (f3 == 3'd5) begin
                    s.legal = (f7 == 7'h00) || (f7 == 7'h20);
                    if (f7 == 7'h20) s.alu = 4'd8;
                end
            end
            7'h37: begin s.imm = 3'd4; s.bsel = 1'b1; s.alu = 4'd11; s.wb = 2'd1; s.legal = 1'b1; end
            7'h17: begin s.imm = 3'd4; s.asel = 1'b1; s.bsel = 1'b1; s.alu = 4'd1; s.wb = 2'd1; s.legal = 1'b1; end
            7'h6F: begin s.imm = 3'd5; s.asel = 1'b1; s.bsel = 1'b1; s.alu = 4'd1; s.wb = 2'd2; s.legal = 1'b1; s.is_jump = 1'b1; end
            7'h67: begin s.imm = 3'd1; s.bsel = 1'b1; s.alu = 4'd1; s.wb = 2'd2; s.legal = (f3 == 3'd0); s.is_jump = 1'b1; end
            7'h03: begin s.imm = 3'd1; s.bsel = 1'b1; s.alu = 4'd1; s.legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; s.is_load = 1'b1; end
            7'h23: begin s.imm = 3'd2; s.bsel = 1'b1; s.alu = 4'd1; s.legal = (f3 <= 3'd2); s.is_store = 1'b1; end
            7'h63: begin s.imm = 3'd3; s.asel = 1'b1; s.bsel = 1'b1; s.alu = 4'd1; s.legal = !(f3 inside {3'd2, 3'd3}); s.is_branch = 1'b1; end
            default: s.legal = 1'b0;
        endcase
        return s;
    endfunction

    // beq/bne/blt/bge/bltu/bgeu outcome from the comparator flags.
    function automatic logic taken(input logic [2:0] f3, input logic breq, input logic brlt);
        case (f3)
            3'd0: return breq;
            3'd1: return !breq;
            3'd4, 3'd6: return brlt;
            default: return !brlt;
        endcase
    endfunction

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.instret = CNT_W'(m_instret);
        o.trap    = m_trapped;
        o.cause   = m_trapped ? m_cause : 2'd0;
        return o;
    endfunction

    task automatic push(input logic r, input logic [31:0] w, input logic rdy,
                        input logic be, input logic bl, input obs_t e, input string tag);
        step_t s;
        s.rst = r; s.inst = w; s.ready = rdy; s.breq = be; s.brlt = bl; s.exp = e; s.tag = tag;
        q.push_back(s);
    endtask

    task automatic do_reset(input int n);
        m_instret = 0; m_trapped = 1'b0; m_cause = 2'd0;
        for (int i = 0; i < n; i++) push(1'b1, 32'h002081B3, 1'b1, 1'b1, 1'b1, obs_t'(0), "reset");
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 32'h002081B3, 1'b1, 1'b1, 1'b1, idle_obs(), "trap");
    endtask

    task automatic run_inst(input string tag, input logic [31:0] w, input int fwait, input int mwait,
                            input logic be, input logic bl, input bit abort_mem);
        spec_t s;
        obs_t  e, d;
        s = spec_of(w);
        for (int k = 1; k <= fwait; k++) begin
            e = idle_obs(); e.mem_req = 1'b1;
            push(1'b0, w, 1'b0, be, bl, e, {tag, ".fwait"});
            if (k == MEM_TIMEOUT) begin m_trapped = 1'b1; m_cause = 2'd2; return; end
        end
        e = idle_obs(); e.mem_req = 1'b1; e.irwen = 1'b1;
        push(1'b0, w, 1'b1, be, bl, e, {tag, ".fetch"});
        push(1'b0, JUNK, 1'b1, be, bl, idle_obs(), {tag, ".decode"});
        if (!s.legal) begin m_trapped = 1'b1; m_cause = 2'd1; return; end
        d = idle_obs(); d.imm = s.imm; d.alu = s.alu; d.wb = s.wb; d.asel = s.asel; d.bsel = s.bsel;
        e = d;
        if (s.is_branch) begin
            e.brun = w[13]; e.pcsel = taken(w[14:12], be, bl); e.pcwen = 1'b1;
            push(1'b0, JUNK, 1'b1, be, bl, e, {tag, ".exec"});
            m_instret++;
            return;
        end
        push(1'b0, JUNK, 1'b1, be, bl, e, {tag, ".exec"});
        if (s.is_load || s.is_store) begin
            for (int k = 1; k <= mwait; k++) begin
                e = d; e.mem_req = 1'b1; e.memrw = s.is_store;
                push(1'b0, JUNK, 1'b0, be, bl, e, {tag, ".mwait"});
                if (k == MEM_TIMEOUT) begin m_trapped = 1'b1; m_cause = 2'd3; return; end
            end
            if (abort_mem) return;
            e = d; e.mem_req = 1'b1; e.memrw = s.is_store; e.pcwen = s.is_store;
            push(1'b0, JUNK, 1'b1, be, bl, e, {tag, ".mem"});
            if (s.is_store) begin m_instret++; return; end
        end
        e = d; e.regwen = 1'b1; e.pcwen = 1'b1; e.pcsel = s.is_jump;
        push(1'b0, JUNK, 1'b1, be, bl, e, {tag, ".wb"});
        m_instret++;
    endtask

    obs_t act;
    always_comb begin
        act         = '0;
        act.mem_req = mem_req;  act.memrw  = mem_rw;  act.pcsel = pc_sel;  act.pcwen = pc_wen;
        act.irwen   = ir_wen;   act.imm    = imm_sel; act.regwen = reg_wen; act.brun = br_un;
        act.asel    = a_sel;    act.bsel   = b_sel;   act.alu   = 4'(alu_sel); act.wb = wb_sel;
        act.instret = instret;  act.trap   = trap;    act.cause = cause;
    end

    initial begin
        int n0;
        spec_t s;
        // Literal pins on the model itself.
        s = spec_of(32'h002081B3);
        check("model.add.alu", 64'(s.alu), 64'd1);
        check("model.add.wb", 64'(s.wb), 64'd1);
        s = spec_of(32'h0000A183);
        check("model.lw.imm", 64'(s.imm), 64'd1);
        check("model.lw.wb", 64'(s.wb), 64'd0);
        s = spec_of(32'h0020A023);
        check("model.sw.imm", 64'(s.imm), 64'd2);
        s = spec_of(32'hFFFFFFFF);
        check("model.ones.legal", 64'(s.legal), 64'd0);

        do_reset(2);
        n0 = q.size(); run_inst("add", 32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);
        check("model.add.cycles", 64'(q.size() - n0), 64'd4);
        n0 = q.size(); run_inst("beq_t", 32'h00208463, 0, 0, 1'b1, 1'b0, 1'b0);
        check("model.beq.cycles", 64'(q.size() - n0), 64'd3);
        run_inst("beq_nt", 32'h00208463, 0, 0, 1'b0, 1'b1, 1'b0);
        run_inst("bne", 32'h00209463, 0, 0, 1'b0, 1'b0, 1'b0);
        run_inst("blt", 32'h0020C463, 0, 0, 1'b0, 1'b1, 1'b0);
        run_inst("bltu", 32'h0020E463, 0, 0, 1'b1, 1'b0, 1'b0);
        n0 = q.size(); run_inst("lw", 32'h0000A183, 0, 3, 1'b0, 1'b0, 1'b0);
        check("model.lw.cycles", 64'(q.size() - n0), 64'd8);
        run_inst("sw", 32'h0020A023, 2, 0, 1'b0, 1'b0, 1'b0);
        run_inst("lui", 32'h123450B7, 0, 0, 1'b0, 1'b0, 1'b0);
        run_inst("auipc", 32'h00001097, 1, 0, 1'b0, 1'b0, 1'b0);
        run_inst("jal", 32'h000000EF, 0, 0, 1'b0, 1'b0, 1'b0);
        run_inst("jalr", 32'h000100E7, 0, 0, 1'b0, 1'b0, 1'b0);
        run_inst("addi", 32'h00510093, 0, 0, 1'b0, 1'b0, 1'b0);
        run_inst("slli", 32'h00311093, 0, 0, 1'b0, 1'b0, 1'b0);
        run_inst("sub", 32'h402081B3, 0, 0, 1'b0, 1'b0, 1'b0);
        run_inst("sra", 32'h4020D1B3, 0, 0, 1'b0, 1'b0, 1'b0);
        run_inst("or", 32'h0020E1B3, 0, 0, 1'b0, 1'b0, 1'b0);
        check("model.instret.wrapped", 64'(CNT_W'(m_instret)), 64'd1);
        run_inst("illegal", 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, 1'b0);
        trap_hold(4);
        do_reset(1);
        run_inst("mul", 32'h022081B3, 0, 0, 1'b0, 1'b0, 1'b0);
        trap_hold(2);
        do_reset(1);
        run_inst("fetch_to", 32'h002081B3, 6, 0, 1'b0, 1'b0, 1'b0);
        trap_hold(3);
        do_reset(1);
        run_inst("lw_to", 32'h0000A183, 0, 6, 1'b0, 1'b0, 1'b0);
        trap_hold(3);
        do_reset(1);
        run_inst("add2", 32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);
        run_inst("lw_abort", 32'h0000A183, 0, 2, 1'b0, 1'b0, 1'b1);
        do_reset(2);
        run_inst("add3", 32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #1;
        for (int i = 0; i < q.size(); i++) begin
            rst       = q[i].rst;
            inst      = q[i].inst;
            mem_ready = q[i].ready;
            br_eq     = q[i].breq;
            br_lt     = q[i].brlt;
            @(negedge clk);
            check($sformatf("%s@%0d", q[i].tag, i), 64'(act), 64'(q[i].exp));
            @(posedge clk);
            #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max cycles mem_req may wait for mem_ready before trapping.
REQ-002 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-003 Parameter ALU_W, default 4: ALUSel width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 inst  in  32  instruction word from memory; sampled only in FETCH when mem_ready=1.
REQ-007 mem_ready  in  1  memory accepted/completed current request.
REQ-008 BrEq, BrLt  in  1 each  branch comparator results.
REQ-009 mem_req  out  1  memory request, held until mem_ready.
REQ-010 MemRW  out  1  0=read, 1=write.
REQ-011 PCSel, PCWEn, IRWEn  out  1 each  next-PC select (1=ALU), PC write enable, IR write enable.
REQ-012 immSel  out  3  R=0, I=1, S=2, B=3, U=4, J=5.
REQ-013 RegWEn, BrUn, Asel, Bsel  out  1 each  Asel 1=PC, Bsel 1=imm.
REQ-014 ALUSel  out  ALU_W  df=0, add=1, sub=2, sll=3, slt=4, sltu=5, xor=6, srl=7, sra=8, or=9, and=10, passb=11.
REQ-015 WBSel  out  2  0=mem, 1=ALU, 2=PC+4.
REQ-016 instret  out  CNT_W  retired-instruction count, wraps to 0.
REQ-017 trap, cause  out  1, 2  trap flag; cause 0=none, 1=illegal, 2=fetch timeout, 3=mem timeout.

Function
REQ-018 States FETCH, DECODE, EXEC, MEM, WB, TRAP; one-hot or binary, registered.
REQ-019 FETCH: mem_req=1, MemRW=0; on mem_ready IRWEn=1, IR<=inst, ->DECODE; mem_ready on first request cycle is accepted (zero wait).
REQ-020 DECODE: one cycle; unsupported opcode/funct3/funct7 ->TRAP cause=1; else ->EXEC.
REQ-021 EXEC: ALU controls per RV32I decode of IR; R/OP-IMM/LUI/AUIPC/JAL/JALR ->WB; load/store ->MEM; branch ->FETCH.
REQ-022 Branch in EXEC: immSel=B, Asel=1, Bsel=1, ALUSel=add, BrUn=funct3[1]; PCSel = (funct3[2]?BrLt:BrEq) XOR funct3[0], sampled combinationally this cycle; PCWEn=1; instret+1.
REQ-023 LUI: immSel=U, Bsel=1, ALUSel=passb; AUIPC: immSel=U, Asel=1, Bsel=1, add.
REQ-024 JAL: immSel=J, Asel=1; JALR: immSel=I, Asel=0; both Bsel=1, add, WBSel=2, PCSel=1 in WB.
REQ-025 MEM: immSel I (load) or S (store), Asel=0, Bsel=1, add, mem_req=1, MemRW=1 for store; on mem_ready: store ->FETCH with PCWEn=1, instret+1; load ->WB.
REQ-026 WB: RegWEn=1 exactly one cycle, PCWEn=1, WBSel per class, instret+1, ->FETCH.
REQ-027 Wait counter counts consecutive mem_req cycles without mem_ready; reaching MEM_TIMEOUT ->TRAP, cause=2 (FETCH) or 3 (MEM); counter clears on mem_ready or state change.
REQ-028 TRAP: sticky; trap=1, all enables (mem_req, RegWEn, PCWEn, IRWEn, MemRW) 0; exits only via rst.
REQ-029 Outside asserting states every enable is 0; immSel/ALUSel/Asel/Bsel/WBSel hold decode of IR in EXEC/MEM/WB, 0 elsewhere.
REQ-030 Each retired instruction asserts PCWEn exactly once; RegWEn never asserted for branch/store.

Reset
REQ-031 rst sampled high: next state FETCH, IR=0, wait counter=0, instret=0, trap=0, cause=0, all outputs 0; applies from any state including mid-MEM and TRAP.
REQ-032 rst overrides mem_ready in same cycle; no IR capture or count occurs.

Structure
REQ-033 Shared package holds state enum, immSel, ALUSel, WBSel and cause encodings, RV32I opcode constants.
REQ-034 One sub-module, rv32i_decoder: combinational IR -> {class, ALU controls, illegal}; FSM and counters in top.

Verification
REQ-035 add x3,x1,x2 (0x002081B3), mem_ready=1 -> FETCH,DECODE,EXEC,WB in 4 cycles; ALUSel=1, WBSel=1, RegWEn only in WB; instret 0->1.
REQ-036 beq (0x00208463) BrEq=1 -> PCSel=1, PCWEn=1 in EXEC, 3 cycles, no RegWEn; BrEq=0 -> PCSel=0.
REQ-037 lw (0x0000A183), mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, MemRW=0, then WB with WBSel=0.
REQ-038 sw (0x0020A023) -> MemRW=1 only in MEM, immSel=2, no WB state, instret+1.
REQ-039 inst 0xFFFFFFFF -> TRAP cause=1; MEM_TIMEOUT=4 with mem_ready=0 in FETCH -> cause=2 after 4 cycles; both hold until rst.
REQ-040 rst asserted during MEM wait -> next cycle FETCH, all outputs 0, instret=0.
